// File: rtl/riscv_pkg.sv
// Shared RISC-V constants, fetch FSM encodings and instruction-buffer entry type
// for the instruction fetch unit.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      FS_RST   = 2'd0,
      FS_FETCH = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic            pred;
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } ibuf_entry_t;

   // Sign-extended B-type branch offset.
   function automatic logic [XLEN-1:0] imm_b(input logic [ILEN-1:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; DEPTH must be a power of two so the pointers wrap
// naturally. Push while full is accepted only together with a pop.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage is reset so the read port shows zeros out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, in-order response
// buffering and redirect flush. Static backward-branch prediction: FETCH_STATIC_PREDICT_EN.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_pred_taken,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int EW = $bits(ibuf_entry_t);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d, out_next;
   logic [CW-1:0]   disc_q, disc_d;
   logic [CW-1:0]   ibuf_cnt, tag_cnt;
   logic [SW-1:0]   credit_used;
   logic            fire, rsp_take, pop, flush, pred_hit;
   logic            ibuf_full, ibuf_empty, tag_full, tag_empty;
   logic [XLEN-1:0] tag_pc, pred_target;
   ibuf_entry_t     wr_e, rd_e;
   logic            unused_ok;

   assign fire     = imem_req_valid & imem_req_ready;
   // Responses owed to a flushed stream are dropped without touching the tag queue.
   assign rsp_take = imem_rsp_valid & (disc_q == '0) & ~redirect_valid;
   assign pop      = instr_valid & instr_ready & ~redirect_valid;
   assign out_next = out_q + CW'(fire) - CW'(imem_rsp_valid);

`ifdef FETCH_STATIC_PREDICT_EN
   assign pred_hit    = rsp_take & (imem_rsp_data[6:0] == OPC_BRANCH) & imem_rsp_data[31];
   assign pred_target = tag_pc + imm_b(imem_rsp_data);
`else
   assign pred_hit    = 1'b0;
   assign pred_target = tag_pc;
`endif

   assign flush = redirect_valid | pred_hit;

   // Only registered state feeds the request valid.
   assign credit_used    = SW'(out_q) + SW'(ibuf_cnt);
   assign imem_req_valid = (state_q == FS_FETCH) && (credit_used < SW'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;

   assign wr_e = '{pred: pred_hit, pc: tag_pc, instr: imem_rsp_data};

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fire & ~flush),
      .pop   (rsp_take),
      .clear (flush),
      .wdata (pc_q),
      .rdata (tag_pc),
      .count (tag_cnt),
      .full  (tag_full),
      .empty (tag_empty)
   );

   fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_ibuf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_take),
      .pop   (pop),
      .clear (redirect_valid),
      .wdata (wr_e),
      .rdata (rd_e),
      .count (ibuf_cnt),
      .full  (ibuf_full),
      .empty (ibuf_empty)
   );

   assign instr_valid      = ~ibuf_empty;
   assign instr            = rd_e.instr;
   assign instr_pc         = rd_e.pc;
   assign instr_pred_taken = rd_e.pred;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_next;
      disc_d  = disc_q;
      if (fire) pc_d = pc_q + 32'd4;
      case (state_q)
         FS_RST:   state_d = FS_FETCH;
         FS_DRAIN: begin
            if (imem_rsp_valid && (disc_q != '0)) begin
               disc_d = disc_q - CW'(1);
               if (disc_q == CW'(1)) state_d = FS_FETCH;
            end
         end
         default: ;
      endcase
      // A taken prediction keeps the buffer but drops everything issued after the branch.
      if (pred_hit) begin
         pc_d    = pred_target;
         disc_d  = out_next;
         state_d = (out_next == '0) ? FS_FETCH : FS_DRAIN;
      end
      if (redirect_valid) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         disc_d  = out_next;
         state_d = (out_next == '0) ? FS_FETCH : FS_DRAIN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FS_RST;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         disc_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
      end
   end

   assign unused_ok = ^{tag_cnt, tag_full, tag_empty, ibuf_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table after reset plus stall, redirect,
// wrap, branch-prediction and mid-run reset sequences against a 1-cycle memory model.
module tb_instr_fetch_unit;

`ifdef FETCH_STATIC_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid, instr_ready, instr_pred_taken;
   logic [31:0] instr, instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr            (instr),
      .instr_pc         (instr_pc),
      .instr_pred_taken (instr_pred_taken),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc)
   );

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] pc;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   int          n_pop = 0;
   logic [31:0] exp_pc = 32'h0;
   bit          mem_hold = 1'b0;
   bit          br_en = 1'b0;
   logic [31:0] pend[$];
   logic [31:0] fire_log[$];
   logic        s_rv, s_iv, s_pred;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (br_en && a == 32'h20) return 32'hFE00_1CE3;  // bne x0,x0,-8
      return a | 32'h13;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic score();
      logic ep;
      ep = PRED_EN && br_en && (s_pc == 32'h20);
      n_pop++;
      chk("pop_pc", s_pc, exp_pc);
      chk("pop_instr", s_instr, memfn(s_pc));
      chk("pop_pred", {31'b0, s_pred}, {31'b0, ep});
      exp_pc = ep ? 32'h18 : s_pc + 32'd4;
   endtask

   // One clock: sample at negedge, then play the memory model just after posedge.
   task automatic cyc();
      logic f, p;
      @(negedge clk);
      s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = instr_valid;
      s_pc = instr_pc; s_instr = instr; s_pred = instr_pred_taken;
      f = s_rv && imem_req_ready;
      p = s_iv && instr_ready && !redirect_valid;
      if (f) fire_log.push_back(s_addr);
      if (p) score();
      @(posedge clk);
      #1;
      if (f) pend.push_back(s_addr);
      if (!mem_hold && pend.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memfn(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   vec_t tbl[11];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bit found;
      tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[3]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
      tbl[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
      tbl[5]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
      tbl[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
      tbl[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
      tbl[8]  = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
      tbl[9]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
      tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};

      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_pred", {31'b0, instr_pred_taken}, 32'h0);
      rst_n = 1'b1;

      // 1: sequential stream, cycle-accurate credit pattern
      for (int i = 0; i < 11; i++) begin
         instr_ready = tbl[i].rdy;
         cyc();
         chk($sformatf("t1_rv[%0d]", i), {31'b0, s_rv}, {31'b0, tbl[i].rv});
         chk($sformatf("t1_addr[%0d]", i), s_addr, tbl[i].addr);
         chk($sformatf("t1_iv[%0d]", i), {31'b0, s_iv}, {31'b0, tbl[i].iv});
         if (tbl[i].iv) chk($sformatf("t1_pc[%0d]", i), s_pc, tbl[i].pc);
      end

      // 2: decode stall
      instr_ready = 1'b0;
      fire_log.delete();
      repeat (10) cyc();
      chk("t2_fires_le_depth", {31'b0, fire_log.size() <= 2}, 32'h1);
      chk("t2_full_valid", {31'b0, s_iv}, 32'h1);
      chk("t2_no_credit", {31'b0, s_rv}, 32'h0);
      instr_ready = 1'b1;
      n0 = n_pop;
      repeat (8) cyc();
      chk("t2_drained", {31'b0, (n_pop - n0) >= 2}, 32'h1);

      // 3: redirect with two requests in flight
      mem_hold = 1'b1;
      repeat (6) cyc();
      chk("t3_inflight", pend.size(), 32'd2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; exp_pc = 32'h100;
      mem_hold = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      chk("t3_iv_after", {31'b0, instr_valid}, 32'h0);
      chk("t3_rv_drain", {31'b0, imem_req_valid}, 32'h0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         cyc();
         if (s_rv) found = 1'b1;
      end
      chk("t3_first_addr", found ? s_addr : 32'hDEAD_BEEF, 32'h100);
      n0 = n_pop;
      repeat (8) cyc();
      chk("t3_popped", {31'b0, n_pop > n0}, 32'h1);

      // 4: redirect coincident with response and pop
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         cyc();
         if (imem_rsp_valid && instr_valid) found = 1'b1;
      end
      chk("t4_found", {31'b0, found}, 32'h1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; exp_pc = 32'h200;
      cyc();
      redirect_valid = 1'b0;
      chk("t4_iv_after", {31'b0, instr_valid}, 32'h0);
      n0 = n_pop;
      repeat (10) cyc();
      chk("t4_popped", {31'b0, n_pop > n0}, 32'h1);

      // 5: PC wrap
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC;
      cyc();
      redirect_valid = 1'b0;
      fire_log.delete();
      repeat (10) cyc();
      chk("t5_fire0", fire_log.size() > 0 ? fire_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      chk("t5_fire1", fire_log.size() > 1 ? fire_log[1] : 32'hDEAD_BEEF, 32'h0);

      // 6: backward BNE at 0x20
      br_en = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h20; exp_pc = 32'h20;
      cyc();
      redirect_valid = 1'b0;
      fire_log.delete();
      repeat (12) cyc();
      chk("t6_fire0", fire_log.size() > 0 ? fire_log[0] : 32'hDEAD_BEEF, 32'h20);
      chk("t6_fire1", fire_log.size() > 1 ? fire_log[1] : 32'hDEAD_BEEF, 32'h24);
      chk("t6_fire2", fire_log.size() > 2 ? fire_log[2] : 32'hDEAD_BEEF,
          PRED_EN ? 32'h18 : 32'h28);

      // 7: reset in the middle of traffic
      rst_n = 1'b0;
      #1;
      chk("t7_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("t7_req_addr", imem_req_addr, 32'h0);
      chk("t7_instr_valid", {31'b0, instr_valid}, 32'h0);
      chk("t7_instr", instr, 32'h0);
      chk("t7_pc", instr_pc, 32'h0);
      pend.delete();
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      br_en = 1'b0; exp_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n0 = n_pop;
      repeat (10) cyc();
      chk("t7_restart", {31'b0, n_pop > n0}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
